// File: rtl/adc_cap_trig.sv
// -----------------------------------------------------------------------------
// adc_cap_trig
//   Triggered snapshot capture of an AXI4-Stream ADC sample bus into a BRAM
//   controller port. Input beats are packed RATIO-to-one into BRAM words; an
//   arm edge starts a capture which first fills pt words of pre-trigger history,
//   then writes circularly until a trigger, then writes MAX_XFER-pt more words
//   starting with the trigger word and stops in DONE.
//
// Ports
//   aclk, aresetn              clock, asynchronous active-low reset
//   s_axis_tdata/tvalid/tready sample stream (tready is always 1)
//   arm_i                      rising edge starts a capture (IDLE/DONE only)
//   trig_i                     hardware trigger, rising-edge sensitive
//   sw_trig_i                  software trigger, single-cycle pulse
//   pretrig_i                  pre-trigger depth in words, sampled at arm
//   armed_o, done_o            state flags
//   trig_addr_o                word index of the trigger word
//   bram_*                     Xilinx BRAM controller style write port
// -----------------------------------------------------------------------------
module adc_cap_trig #(
   parameter int DWIDTH_IN  = 128,
   parameter int RATIO      = 2,
   parameter int MAX_XFER   = 2048,
   localparam int DWIDTH_OUT = DWIDTH_IN * RATIO,
   localparam int ADDR_BITS  = $clog2(MAX_XFER)
) (
   input  logic                      aclk,
   input  logic                      aresetn,
   input  logic [DWIDTH_IN-1:0]      s_axis_tdata,
   input  logic                      s_axis_tvalid,
   output logic                      s_axis_tready,
   input  logic                      arm_i,
   input  logic                      trig_i,
   input  logic                      sw_trig_i,
   input  logic [ADDR_BITS-1:0]      pretrig_i,
   output logic                      armed_o,
   output logic                      done_o,
   output logic [ADDR_BITS-1:0]      trig_addr_o,
   output logic [DWIDTH_OUT-1:0]     bram_wdata,
   output logic [DWIDTH_OUT/8-1:0]   bram_we,
   output logic                      bram_en,
   input  logic [DWIDTH_OUT-1:0]     bram_rdata,
   output logic [31:0]               bram_addr,
   output logic                      bram_clk,
   output logic                      bram_rst
);

   localparam int BYTES   = DWIDTH_OUT / 8;
   localparam int PH_BITS = (RATIO > 1) ? $clog2(RATIO) : 1;
   localparam logic [PH_BITS-1:0]   PH_LAST  = PH_BITS'(RATIO - 1);
   localparam logic [ADDR_BITS-1:0] LAST_IDX = ADDR_BITS'(MAX_XFER - 1);

   typedef enum logic [2:0] {IDLE, FILL, ARMED, POST, DONE} state_t;

   state_t                 state;
   logic [PH_BITS-1:0]     phase;
   logic [DWIDTH_IN-1:0]   acc [RATIO];
   logic [ADDR_BITS-1:0]   wp;
   logic [ADDR_BITS-1:0]   pt;
   logic [ADDR_BITS-1:0]   rem;       // POST writes still outstanding
   logic                   pending;   // trigger seen in ARMED, waiting for a write
   logic                   arm_d;
   logic                   trig_d;

   logic                   arm_take;
   logic                   trig_evt;
   logic                   beat_last;
   logic                   capturing;
   logic                   fire;
   logic [DWIDTH_OUT-1:0]  word_asm;
   logic                   unused_rdata;

   assign s_axis_tready = 1'b1;
   assign bram_clk      = aclk;
   assign bram_rst      = ~aresetn;
   assign bram_we       = {BYTES{bram_en}};
   assign unused_rdata  = ^bram_rdata;

   assign arm_take  = arm_i && !arm_d && (state == IDLE || state == DONE);
   assign trig_evt  = (trig_i && !trig_d) || sw_trig_i;
   assign capturing = (state == FILL) || (state == ARMED) || (state == POST);
   // The beat presented in the arm cycle is dropped along with any partial word.
   assign beat_last = s_axis_tvalid && !arm_take && (phase == PH_LAST);
   assign fire      = beat_last && capturing;

   // Assembled word: the slot selected by phase takes the live beat, all other
   // slots come from the accumulator. Only used when phase is the last slot.
   generate
      for (genvar gi = 0; gi < RATIO; gi++) begin : g_slot
         assign word_asm[gi*DWIDTH_IN +: DWIDTH_IN] =
            (phase == PH_BITS'(gi)) ? s_axis_tdata : acc[gi];
      end
   endgenerate

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state       <= IDLE;
         phase       <= '0;
         for (int i = 0; i < RATIO; i++) acc[i] <= '0;
         wp          <= '0;
         pt          <= '0;
         rem         <= '0;
         pending     <= 1'b0;
         arm_d       <= 1'b0;
         trig_d      <= 1'b0;
         armed_o     <= 1'b0;
         done_o      <= 1'b0;
         trig_addr_o <= '0;
         bram_en     <= 1'b0;
         bram_wdata  <= '0;
         bram_addr   <= '0;
      end else begin
         arm_d   <= arm_i;
         trig_d  <= trig_i;
         bram_en <= fire;

         // Gearbox
         if (arm_take) begin
            phase <= '0;
         end else if (s_axis_tvalid) begin
            acc[phase] <= s_axis_tdata;
            phase      <= (phase == PH_LAST) ? '0 : phase + 1'b1;
            if (phase == PH_LAST) bram_wdata <= word_asm;
         end

         if (fire) begin
            bram_addr <= 32'(wp) * 32'(BYTES);
            wp        <= wp + 1'b1;
         end

         case (state)
            IDLE, DONE: begin
               if (arm_take) begin
                  pt      <= pretrig_i;
                  wp      <= '0;
                  pending <= 1'b0;
                  done_o  <= 1'b0;
                  if (pretrig_i != '0) begin
                     state <= FILL;
                  end else begin
                     state   <= ARMED;
                     armed_o <= 1'b1;
                  end
               end
            end
            FILL: begin
               // wp counts FILL writes since it restarts at 0 on arm
               if (fire && (wp + 1'b1) == pt) begin
                  state   <= ARMED;
                  armed_o <= 1'b1;
               end
            end
            ARMED: begin
               // A trigger coinciding with a write makes that write the trigger word
               if (fire && (pending || trig_evt)) begin
                  trig_addr_o <= wp;
                  rem         <= LAST_IDX - pt;
                  pending     <= 1'b0;
                  armed_o     <= 1'b0;
                  if (pt == LAST_IDX) begin
                     state  <= DONE;
                     done_o <= 1'b1;
                  end else begin
                     state <= POST;
                  end
               end else if (trig_evt) begin
                  pending <= 1'b1;
               end
            end
            POST: begin
               if (fire) begin
                  rem <= rem - 1'b1;
                  if (rem == ADDR_BITS'(1)) begin
                     state  <= DONE;
                     done_o <= 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_adc_cap_trig.sv
// -----------------------------------------------------------------------------
// tb_adc_cap_trig
//   Self-checking bench for adc_cap_trig with default parameters. The reference
//   model keeps every accepted beat since arm in a queue; the expected capture
//   is derived from it: write k holds beats k*RATIO.. packed LSB first at word
//   index k mod MAX_XFER, the trigger word is the first word completed at or
//   after an honoured trigger, and the capture ends MAX_XFER-pt words later.
// -----------------------------------------------------------------------------
module tb_adc_cap_trig;

   localparam int DW   = 128;
   localparam int R    = 2;
   localparam int MAXX = 2048;
   localparam int AB   = 11;
   localparam int DWO  = DW * R;
   localparam int BY   = DWO / 8;

   logic            aclk = 1'b0;
   logic            aresetn = 1'b1;
   logic [DW-1:0]   s_axis_tdata = '0;
   logic            s_axis_tvalid = 1'b0;
   logic            s_axis_tready;
   logic            arm_i = 1'b0;
   logic            trig_i = 1'b0;
   logic            sw_trig_i = 1'b0;
   logic [AB-1:0]   pretrig_i = '0;
   logic            armed_o;
   logic            done_o;
   logic [AB-1:0]   trig_addr_o;
   logic [DWO-1:0]  bram_wdata;
   logic [BY-1:0]   bram_we;
   logic            bram_en;
   logic [DWO-1:0]  bram_rdata = '0;
   logic [31:0]     bram_addr;
   logic            bram_clk;
   logic            bram_rst;

   adc_cap_trig #(.DWIDTH_IN(DW), .RATIO(R), .MAX_XFER(MAXX)) dut (
      .aclk(aclk), .aresetn(aresetn),
      .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
      .arm_i(arm_i), .trig_i(trig_i), .sw_trig_i(sw_trig_i), .pretrig_i(pretrig_i),
      .armed_o(armed_o), .done_o(done_o), .trig_addr_o(trig_addr_o),
      .bram_wdata(bram_wdata), .bram_we(bram_we), .bram_en(bram_en),
      .bram_rdata(bram_rdata), .bram_addr(bram_addr),
      .bram_clk(bram_clk), .bram_rst(bram_rst)
   );

   always #5 aclk = ~aclk;

   int checks = 0;
   int errors = 0;

   // Write log captured away from the active edge
   logic [31:0]    wr_addr_q[$];
   logic [DWO-1:0] wr_data_q[$];
   int             we_bad = 0;

   always @(negedge aclk) begin
      if (bram_en === 1'b1) begin
         wr_addr_q.push_back(bram_addr);
         wr_data_q.push_back(bram_wdata);
         $display("write #%0d addr=0x%08h", wr_addr_q.size() - 1, bram_addr);
      end
      if (bram_we !== {BY{bram_en}}) we_bad++;
   end

   // Reference model state
   logic [DW-1:0] beat_q[$];
   int            cur_pt = 0;
   bit            trig_seen = 0;
   int            trig_word = 0;
   bit            pat_mode = 0;
   int            pat_n = 0;

   // One clock cycle of stimulus; accepted beats go into the model.
   task automatic cyc(input bit v, input bit a, input bit t, input bit s);
      logic [DW-1:0] b;
      if (pat_mode) begin
         for (int i = 0; i < DW / 16; i++) b[16*i +: 16] = 16'(pat_n * (DW / 16) + i);
         if (v) pat_n++;
      end else begin
         b = {$urandom, $urandom, $urandom, $urandom};
      end
      s_axis_tdata  = b;
      s_axis_tvalid = v;
      arm_i         = a;
      trig_i        = t;
      sw_trig_i     = s;
      if (v && !a && aresetn) beat_q.push_back(b);
      @(posedge aclk);
      #1;
   endtask

   // Call just before the cycle that presents a trigger edge/pulse.
   task automatic note_trig();
      int w;
      w = beat_q.size() / R;
      if (!trig_seen && w >= cur_pt) begin
         trig_seen = 1;
         trig_word = w;
      end
   endtask

   task automatic do_arm(input int pt, input bit t);
      pretrig_i = AB'(pt);
      cur_pt    = pt;
      trig_seen = 0;
      beat_q.delete();
      wr_addr_q.delete();
      wr_data_q.delete();
      cyc(1, 1, t, 0);
   endtask

   task automatic feed(input int nwords, input int pct);
      int g = 0;
      while (beat_q.size() < nwords * R && g < 50000) begin
         cyc($urandom_range(0, 99) < pct, 0, 0, 0);
         g++;
      end
   endtask

   task automatic run_to_done(input int pct);
      int g = 0;
      while (done_o !== 1'b1 && g < 20000) begin
         cyc($urandom_range(0, 99) < pct, 0, 0, 0);
         g++;
      end
      checks++;
      if (done_o !== 1'b1) begin
         errors++;
         $display("FAIL done_timeout: done_o=%b after %0d cycles, required 1", done_o, g);
      end
      repeat (10) cyc(1, 0, 0, 0);
   endtask

   // Number of logged writes (first n) that disagree with the model.
   function automatic int count_bad_writes(input int n);
      int bad = 0;
      logic [DWO-1:0] e;
      for (int k = 0; k < n && k < wr_addr_q.size(); k++) begin
         e = '0;
         for (int r = 0; r < R; r++) begin
            if (k * R + r < beat_q.size()) e[r*DW +: DW] = beat_q[k * R + r];
            else bad++;
         end
         if (wr_data_q[k] !== e) bad++;
         if (wr_addr_q[k] !== 32'((k % MAXX) * BY)) bad++;
      end
      return bad;
   endfunction

   task automatic test_reset();
      aresetn = 1'b0;
      #3;
      checks++;
      if (bram_en !== 1'b0 || bram_we !== '0 || bram_wdata !== '0 || bram_addr !== '0) begin
         errors++;
         $display("FAIL reset_bram: en=%b we=%h addr=%h, required all 0", bram_en, bram_we, bram_addr);
      end
      checks++;
      if (armed_o !== 1'b0 || done_o !== 1'b0 || trig_addr_o !== '0) begin
         errors++;
         $display("FAIL reset_flags: armed=%b done=%b trig_addr=%0d, required 0/0/0", armed_o, done_o, trig_addr_o);
      end
      checks++;
      if (bram_rst !== 1'b1 || s_axis_tready !== 1'b1) begin
         errors++;
         $display("FAIL reset_misc: bram_rst=%b tready=%b, required 1/1", bram_rst, s_axis_tready);
      end
      @(posedge aclk);
      #1;
      aresetn = 1'b1;
      repeat (3) cyc(1, 0, 0, 0);
      $display("test_reset done");
   endtask

   task automatic test_full_pt0();
      int bad;
      pat_mode = 1;
      pat_n    = 0;
      do_arm(0, 0);
      checks++;
      if (armed_o !== 1'b1) begin
         errors++;
         $display("FAIL t1_armed: armed_o=%b, required 1", armed_o);
      end
      note_trig();
      cyc(1, 0, 0, 1);
      run_to_done(100);
      checks++;
      if (trig_addr_o !== AB'(0)) begin
         errors++;
         $display("FAIL t1_trig_addr: got %0d, required 0", trig_addr_o);
      end
      checks++;
      if (wr_addr_q.size() != MAXX) begin
         errors++;
         $display("FAIL t1_count: got %0d writes, required %0d", wr_addr_q.size(), MAXX);
      end
      bad = count_bad_writes(MAXX);
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL t1_contents: %0d bad fields, required 0", bad);
      end
      checks++;
      if (wr_addr_q.size() > 0 && wr_addr_q[wr_addr_q.size() - 1] !== 32'd65504) begin
         errors++;
         $display("FAIL t1_last_addr: got %0d, required 65504", wr_addr_q[wr_addr_q.size() - 1]);
      end
      pat_mode = 0;
      $display("test_full_pt0 done: writes=%0d", wr_addr_q.size());
   endtask

   task automatic test_hw_trig();
      int bad;
      do_arm(256, 0);
      feed(1000, 100);
      checks++;
      if (armed_o !== 1'b1) begin
         errors++;
         $display("FAIL t2_armed: armed_o=%b, required 1", armed_o);
      end
      note_trig();
      cyc(1, 0, 1, 0);
      run_to_done(100);
      checks++;
      if (trig_addr_o !== AB'(1000)) begin
         errors++;
         $display("FAIL t2_trig_addr: got %0d, required 1000", trig_addr_o);
      end
      checks++;
      if (wr_addr_q.size() != 2792) begin
         errors++;
         $display("FAIL t2_count: got %0d writes, required 2792", wr_addr_q.size());
      end
      checks++;
      if (wr_addr_q.size() > 0 && wr_addr_q[wr_addr_q.size() - 1] !== 32'(743 * BY)) begin
         errors++;
         $display("FAIL t2_last_addr: got %0d, required %0d", wr_addr_q[wr_addr_q.size() - 1], 743 * BY);
      end
      bad = count_bad_writes(2792);
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL t2_contents: %0d bad fields, required 0", bad);
      end
      $display("test_hw_trig done: writes=%0d", wr_addr_q.size());
   endtask

   task automatic test_fill_ignore();
      int bad;
      int exp_total;
      do_arm(256, 0);
      feed(100, 100);
      note_trig();
      cyc(1, 0, 1, 0);
      feed(2100, 100);
      cyc(0, 0, 0, 0);
      checks++;
      if (armed_o !== 1'b1 || done_o !== 1'b0) begin
         errors++;
         $display("FAIL t3_still_armed: armed=%b done=%b, required 1/0", armed_o, done_o);
      end
      checks++;
      if (wr_addr_q.size() != 2100 || wr_addr_q[wr_addr_q.size() - 1] !== 32'(51 * BY)) begin
         errors++;
         $display("FAIL t3_wrap: got %0d writes, required 2100 ending at addr %0d", wr_addr_q.size(), 51 * BY);
      end
      note_trig();
      cyc(1, 0, 0, 1);
      run_to_done(100);
      exp_total = trig_word + MAXX - cur_pt;
      checks++;
      if (trig_addr_o !== AB'(trig_word % MAXX)) begin
         errors++;
         $display("FAIL t3_trig_addr: got %0d, required %0d", trig_addr_o, trig_word % MAXX);
      end
      bad = count_bad_writes(exp_total);
      checks++;
      if (wr_addr_q.size() != exp_total || bad != 0) begin
         errors++;
         $display("FAIL t3_capture: writes=%0d bad=%0d, required %0d/0", wr_addr_q.size(), bad, exp_total);
      end
      $display("test_fill_ignore done: writes=%0d", wr_addr_q.size());
   endtask

   task automatic test_tvalid_gaps();
      int bad;
      int exp_total;
      int pt;
      pt = $urandom_range(0, 1023);
      do_arm(pt, 0);
      feed(pt + $urandom_range(1, 200), 55);
      note_trig();
      cyc($urandom_range(0, 1) == 1, 0, 0, 1);
      run_to_done(55);
      exp_total = trig_word + MAXX - cur_pt;
      checks++;
      if (trig_addr_o !== AB'(trig_word % MAXX)) begin
         errors++;
         $display("FAIL t4_trig_addr: got %0d, required %0d", trig_addr_o, trig_word % MAXX);
      end
      bad = count_bad_writes(exp_total);
      checks++;
      if (wr_addr_q.size() != exp_total || bad != 0) begin
         errors++;
         $display("FAIL t4_capture: writes=%0d bad=%0d, required %0d/0", wr_addr_q.size(), bad, exp_total);
      end
      $display("test_tvalid_gaps done: pt=%0d writes=%0d", pt, wr_addr_q.size());
   endtask

   task automatic test_reset_mid_post();
      int g = 0;
      int n;
      int bad;
      do_arm(0, 0);
      note_trig();
      cyc(1, 0, 0, 1);
      feed(500, 100);
      while (bram_en !== 1'b1 && g < 10) begin
         cyc(1, 0, 0, 0);
         g++;
      end
      #2;
      aresetn = 1'b0;
      #1;
      checks++;
      if (bram_en !== 1'b0 || bram_we !== '0) begin
         errors++;
         $display("FAIL t5_en_drop: en=%b we=%h, required 0", bram_en, bram_we);
      end
      checks++;
      if (armed_o !== 1'b0 || done_o !== 1'b0 || trig_addr_o !== '0 || bram_addr !== '0 || bram_wdata !== '0) begin
         errors++;
         $display("FAIL t5_reset_vals: armed=%b done=%b trig_addr=%0d addr=%0d", armed_o, done_o, trig_addr_o, bram_addr);
      end
      n = wr_addr_q.size();
      repeat (5) cyc(1, 0, 0, 0);
      checks++;
      if (wr_addr_q.size() != n) begin
         errors++;
         $display("FAIL t5_no_writes: got %0d writes, required %0d", wr_addr_q.size(), n);
      end
      aresetn = 1'b1;
      repeat (2) cyc(1, 0, 0, 0);
      do_arm(0, 0);
      note_trig();
      cyc(1, 0, 0, 1);
      run_to_done(100);
      bad = count_bad_writes(MAXX);
      checks++;
      if (wr_addr_q.size() != MAXX || bad != 0 || trig_addr_o !== AB'(0)) begin
         errors++;
         $display("FAIL t5_recapture: writes=%0d bad=%0d trig_addr=%0d, required %0d/0/0", wr_addr_q.size(), bad, trig_addr_o, MAXX);
      end
      $display("test_reset_mid_post done: writes=%0d", wr_addr_q.size());
   endtask

   task automatic test_arm_trig_same();
      int bad;
      int exp_total;
      do_arm(0, 1);
      checks++;
      if (armed_o !== 1'b1) begin
         errors++;
         $display("FAIL t6_armed: armed_o=%b, required 1", armed_o);
      end
      feed(50, 100);
      cyc(0, 0, 0, 0);
      checks++;
      if (armed_o !== 1'b1 || done_o !== 1'b0 || wr_addr_q.size() != 50) begin
         errors++;
         $display("FAIL t6_no_post: armed=%b done=%b writes=%0d, required 1/0/50", armed_o, done_o, wr_addr_q.size());
      end
      note_trig();
      cyc(1, 0, 0, 1);
      run_to_done(100);
      exp_total = trig_word + MAXX - cur_pt;
      bad = count_bad_writes(exp_total);
      checks++;
      if (trig_addr_o !== AB'(50) || wr_addr_q.size() != exp_total || bad != 0) begin
         errors++;
         $display("FAIL t6_capture: trig_addr=%0d writes=%0d bad=%0d, required 50/%0d/0", trig_addr_o, wr_addr_q.size(), bad, exp_total);
      end
      $display("test_arm_trig_same done: writes=%0d", wr_addr_q.size());
   endtask

   initial begin
      #2;
      test_reset();
      test_full_pt0();
      test_hw_trig();
      test_fill_ignore();
      test_tvalid_gaps();
      test_reset_mid_post();
      test_arm_trig_same();
      checks++;
      if (we_bad != 0) begin
         errors++;
         $display("FAIL we_equals_en: %0d cycles with bram_we != en, required 0", we_bad);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/adc_cap_trig.md
Name: adc_cap_trig

Overview:
Next-generation ADC snapshot capture. Widens a streaming AXI4-Stream ADC sample bus by a parametrised ratio and writes into a Xilinx BRAM-controller port with pre-trigger history. Arm, fill pre-trigger history, wait for a hardware or software trigger, then capture the post-trigger remainder and stop. Single-clock: input stream and BRAM port share aclk. Unlike the earlier capture block, it honours tvalid and supports runtime pre-trigger depth.

Parameters:
DWIDTH_IN, 128, input beat width in bits.
RATIO, 2, input beats per BRAM word (power of 2, 1..8); DWIDTH_OUT = DWIDTH_IN*RATIO.
MAX_XFER, 2048, capture depth in BRAM words (power of 2); ADDR_BITS = log2(MAX_XFER).

Ports:
aclk  in  1  sole clock; BRAM port and stream run on it.
aresetn  in  1  asynchronous active-low reset.
s_axis_tdata  in  DWIDTH_IN  ADC samples.
s_axis_tvalid  in  1  beat valid.
s_axis_tready  out  1  tied 1.
arm_i  in  1  rising edge starts a capture.
trig_i  in  1  hardware trigger, rising-edge sensitive.
sw_trig_i  in  1  software trigger, single-cycle pulse.
pretrig_i  in  ADDR_BITS  pre-trigger words, sampled at arm; must be < MAX_XFER.
armed_o  out  1  high in ARMED.
done_o  out  1  high in DONE.
trig_addr_o  out  ADDR_BITS  word index of trigger word.
bram_wdata  out  DWIDTH_OUT  write data.
bram_we  out  DWIDTH_OUT/8  all bits equal the write strobe.
bram_en  out  1  equals write strobe.
bram_rdata  in  DWIDTH_OUT  unused.
bram_addr  out  32  byte address = word index * (DWIDTH_OUT/8).
bram_clk  out  1  = aclk.
bram_rst  out  1  = !aresetn.

Behaviour:
- Reset (async assert, sync release): state IDLE; bram_en/bram_we 0, bram_wdata 0, bram_addr 0, armed_o 0, done_o 0, trig_addr_o 0; gearbox phase 0; edge detectors 0.
- Gearbox: each tvalid beat is packed at slot = phase, slot 0 in LSBs; phase increments mod RATIO. On the beat completing a word (phase = RATIO-1), the assembled word is registered. If state is FILL/ARMED/POST, one write is issued with the strobe high exactly one cycle, the cycle after that beat. tvalid low: no advance, no write.
- Arm edge clears phase; partial words are discarded.
- Word pointer wp: ADDR_BITS bits, cleared at arm, +1 per write, wraps mod MAX_XFER.
- States:
  - IDLE/DONE, arm edge: latch pretrig_i into pt, wp=0, done_o=0. Go to FILL if pt>0, else ARMED.
  - FILL: count writes; after pt writes go to ARMED. Triggers here are ignored, not queued.
  - ARMED: writes continue circularly. A trigger event (trig_i rising edge OR sw_trig_i) sets a pending flag. The next write is the trigger word: trig_addr_o = wp of that write, remaining = MAX_XFER - pt, go to POST counting that write.
  - POST: each write decrements remaining. The write taking it to 0 is the last; DONE the following cycle.
  - DONE: done_o=1, no writes.
- Triggers in POST/DONE/IDLE are ignored. Arm edge in FILL/ARMED/POST is ignored.
- Arm and trigger in the same cycle in IDLE: arm taken, trigger ignored.
- Result: buffer holds pt words before the trigger word plus MAX_XFER-pt from the trigger word on. Oldest word is at (trig_addr_o - pt) mod MAX_XFER.
- Reset mid-capture: immediate IDLE, strobe drops asynchronously, no further writes.

Test Plan:
1. RATIO=2, tvalid=1, incrementing 16-bit sample pattern, pt=0, arm then sw_trig one cycle later -> ARMED immediately; trig_addr_o=0; exactly 2048 writes at bram_addr 0,32,...,65504; each word = {beat 2k+1, beat 2k}; done_o after last write.
2. pt=256, trig_i edge after 1000 writes -> trigger word index 1000; 1792 POST writes; last write index 743; total writes 2792; done_o=1.
3. pt=256, trig_i pulse during FILL at write 100, no further trigger -> stays ARMED, writes wrap past 2047→0; a later sw_trig is honoured.
4. tvalid toggling 1-0-1 with random gaps -> writes only on every 2nd accepted beat; pairing correct across gaps; no write during stalls.
5. aresetn asserted mid-POST -> bram_en drops same cycle; all outputs at reset values; new arm runs a clean capture with wp from 0.
6. arm_i and trig_i rise same cycle in IDLE with pt=0 -> trigger ignored; armed_o=1; no POST until a later trigger.
